bin_to_ascii_dec: RTL and testbench

BIN_TO_ASCII_DEC -- requirements
Module: bin_to_ascii_dec

---
 rtl/bin_to_ascii_dec.sv | 143 ++++++++++++++
 tb/tb_bin_to_ascii_dec.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_ascii_dec.sv
// Binary to right-justified ASCII decimal converter using a serial double-dabble (shift-and-add-3) core.
// Optional macro BIN2ASCII_SIGNED_EN: treat bin_in as two's complement and emit a '-' sign.
module bin_to_ascii_dec #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned OUT_CHARS = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       bin_in,
  input  logic                   blank_lz,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*OUT_CHARS-1:0] ascii_out
);

  localparam int unsigned ND = (WIDTH * 77) / 256 + 1;
  localparam int unsigned BW = 4 * ND;
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned PW = 4 * OUT_CHARS;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       opnd_q, opnd_d;
  logic [WIDTH-1:0]       mag_c;
  logic [BW-1:0]          bcd_q, bcd_d;
  logic [BW-1:0]          adj_c, bcd_shift_c;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   blank_q, blank_d;
  logic [8*OUT_CHARS-1:0] ascii_d, fmt_c;
  logic [PW-1:0]          dig_c;
  int                     msd_c;

`ifdef BIN2ASCII_SIGNED_EN
  logic neg_q, neg_d, sign_c;
  assign sign_c = bin_in[WIDTH-1];
  // Magnitude of the most negative value wraps to 2^(WIDTH-1), which is still correct unsigned.
  assign mag_c  = sign_c ? (~bin_in) + WIDTH'(1) : bin_in;
`else
  assign mag_c  = bin_in;
`endif

  // Add-3 correction on every nibble >= 5, ahead of the shift.
  always_comb begin
    adj_c = bcd_q;
    for (int i = 0; i < ND; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  assign bcd_shift_c = BW'({adj_c, opnd_q[WIDTH-1]});

  // Format the post-shift BCD value so the final result lands on the DONE edge.
  always_comb begin
    dig_c = PW'(bcd_shift_c);
    msd_c = 0;
    for (int i = 1; i < ND; i++) begin
      if (dig_c[4*i +: 4] != 4'd0) msd_c = i;
    end
    fmt_c = '0;
    for (int i = 0; i < OUT_CHARS; i++) begin
      if (blank_q && (i > msd_c)) fmt_c[8*i +: 8] = 8'h20;
      else                        fmt_c[8*i +: 8] = 8'h30 + 8'(dig_c[4*i +: 4]);
    end
`ifdef BIN2ASCII_SIGNED_EN
    if (neg_q) begin
      if (blank_q) fmt_c[8*(msd_c+1) +: 8]     = 8'h2D;
      else         fmt_c[8*(OUT_CHARS-1) +: 8] = 8'h2D;
    end
`endif
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    opnd_d  = opnd_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    blank_d = blank_q;
    ascii_d = ascii_out;
`ifdef BIN2ASCII_SIGNED_EN
    neg_d   = neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_ready && in_valid) begin
          opnd_d  = mag_c;
          blank_d = blank_lz;
          bcd_d   = '0;
          cnt_d   = CW'(WIDTH);
`ifdef BIN2ASCII_SIGNED_EN
          neg_d   = sign_c;
`endif
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        opnd_d = opnd_q << 1;
        bcd_d  = bcd_shift_c;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          ascii_d = fmt_c;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_valid && out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      opnd_q    <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      blank_q   <= 1'b0;
      ascii_out <= {OUT_CHARS{8'h30}};
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
`ifdef BIN2ASCII_SIGNED_EN
      neg_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      opnd_q    <= opnd_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      blank_q   <= blank_d;
      ascii_out <= ascii_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
`ifdef BIN2ASCII_SIGNED_EN
      neg_q     <= neg_d;
`endif
    end
  end

endmodule

// File: tb/tb_bin_to_ascii_dec.sv
// Randomized self-checking bench for bin_to_ascii_dec: a 32-bit/16-char instance and an 8-bit/4-char instance.
module tb_bin_to_ascii_dec;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic         in_valid, in_ready, blank_lz, out_valid, out_ready;
  logic [31:0]  bin_in;
  logic [127:0] ascii_out;

  logic         in_valid8, in_ready8, blank8, out_valid8, out_ready8;
  logic [7:0]   bin8;
  logic [31:0]  ascii8;

  bin_to_ascii_dec #(.WIDTH(32), .OUT_CHARS(16)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .bin_in(bin_in),
    .blank_lz(blank_lz), .out_valid(out_valid), .out_ready(out_ready), .ascii_out(ascii_out)
  );

  bin_to_ascii_dec #(.WIDTH(8), .OUT_CHARS(4)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .bin_in(bin8),
    .blank_lz(blank8), .out_valid(out_valid8), .out_ready(out_ready8), .ascii_out(ascii8)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: decimal text built with plain division, padded on the left.
  function automatic logic [127:0] model(input logic [63:0] v, input int w, input int oc, input bit blank);
    logic [63:0]  mag;
    logic [127:0] r;
    int           nd;
    bit           neg;
    mag = v & ((64'd1 << w) - 64'd1);
    neg = 1'b0;
`ifdef BIN2ASCII_SIGNED_EN
    if (mag[w-1]) begin
      neg = 1'b1;
      mag = (64'd1 << w) - mag;
    end
`endif
    r  = '0;
    nd = 0;
    do begin
      r[8*nd +: 8] = 8'h30 + 8'(mag % 64'd10);
      mag = mag / 64'd10;
      nd++;
    end while (mag != 64'd0);
    for (int i = nd; i < oc; i++) r[8*i +: 8] = blank ? 8'h20 : 8'h30;
    if (neg) begin
      if (blank) r[8*nd +: 8]     = 8'h2D;
      else       r[8*(oc-1) +: 8] = 8'h2D;
    end
    return r;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick;
    checks++;
    if (in_ready !== 1'b0 || in_ready8 !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready: got %b/%b expected 0/0", in_ready, in_ready8);
    end
    checks++;
    if (out_valid !== 1'b0 || out_valid8 !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b/%b expected 0/0", out_valid, out_valid8);
    end
    checks++;
    if (ascii_out !== {16{8'h30}} || ascii8 !== {4{8'h30}}) begin
      errors++; $display("FAIL reset_ascii: got %h/%h expected all 30", ascii_out, ascii8);
    end
    rst = 1'b0;
    tick;
    checks++;
    if (in_ready !== 1'b1 || in_ready8 !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b/%b expected 1/1", in_ready, in_ready8);
    end
  endtask

  // One conversion on the 32-bit instance; optionally leaves the result pending.
  task automatic conv32(input logic [31:0] v, input bit blank, input bit early_ready, input bit release_out,
                        output logic [127:0] got);
    int n;
    logic [127:0] exp;
    exp = model(64'(v), 32, 16, blank);
    n = 0;
    while (!in_ready && n < 100) begin tick; n++; end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL conv32_ready: got %b expected 1", in_ready); end
    bin_in = v; blank_lz = blank; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    out_ready = early_ready;
    n = 0;
    while (!out_valid && n < 100) begin tick; n++; end
    checks++;
    if (n != 32) begin errors++; $display("FAIL conv32_latency: got %0d expected 32 (v=%h)", n, v); end
    checks++;
    if (ascii_out !== exp) begin
      errors++; $display("FAIL conv32_ascii: got %h expected %h (v=%h blank=%0d)", ascii_out, exp, v, blank);
    end
    got = ascii_out;
    if (release_out) begin
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++; $display("FAIL conv32_handoff: got valid=%b ready=%b expected 0/1", out_valid, in_ready);
      end
    end
  endtask

  task automatic test_convert;
    logic [127:0] got, lit;
    conv32(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, got);
`ifndef BIN2ASCII_SIGNED_EN
    lit = "0000004294967295";
    checks++;
    if (got !== lit) begin errors++; $display("FAIL max_literal: got %h expected %h", got, lit); end
`endif
    conv32(32'd0, 1'b1, 1'b0, 1'b1, got);
    lit = "               0";
    checks++;
    if (got !== lit) begin errors++; $display("FAIL zero_blank_literal: got %h expected %h", got, lit); end
`ifdef BIN2ASCII_SIGNED_EN
    conv32(32'h8000_0000, 1'b1, 1'b0, 1'b1, got);
    lit = "     -2147483648";
    checks++;
    if (got !== lit) begin errors++; $display("FAIL min_neg_blank: got %h expected %h", got, lit); end
    conv32(32'h8000_0000, 1'b0, 1'b0, 1'b1, got);
    lit = "-000002147483648";
    checks++;
    if (got !== lit) begin errors++; $display("FAIL min_neg_zero: got %h expected %h", got, lit); end
`endif
    conv32(32'd1000000000, 1'b1, 1'b1, 1'b1, got);
    conv32(32'd7, 1'b0, 1'b0, 1'b1, got);
    for (int k = 0; k < 10; k++) begin
      conv32((k % 2 == 1) ? $urandom : 32'($urandom_range(0, 99999)), 1'($urandom_range(0, 1)),
             (k % 3 == 0), 1'b1, got);
    end
  endtask

  task automatic test_hold;
    logic [127:0] got, exp;
    logic [31:0]  v;
    v   = $urandom;
    exp = model(64'(v), 32, 16, 1'b1);
    conv32(v, 1'b1, 1'b0, 1'b0, got);
    for (int k = 0; k < 10; k++) begin
      in_valid = (k % 3 == 0);
      bin_in   = $urandom;
      blank_lz = 1'b0;
      tick;
      checks++;
      if (ascii_out !== exp || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL hold_cycle%0d: got ascii=%h ready=%b valid=%b expected %h/0/1", k, ascii_out, in_ready, out_valid, exp);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    repeat (3) begin
      tick;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++; $display("FAIL hold_no_extra_accept: got ready=%b valid=%b expected 1/0", in_ready, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back;
    int n, prev;
    logic [7:0]   v;
    bit           b;
    logic [127:0] exp;
    logic [31:0]  lit;
    lit = "0200";
    out_ready8 = 1'b1;
    prev = 0;
    for (int k = 0; k < 6; k++) begin
      v = (k == 0) ? 8'd200 : 8'($urandom);
      b = (k == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      exp = model(64'(v), 8, 4, b);
      n = 0;
      while (!in_ready8 && n < 50) begin tick; n++; end
      checks++;
      if (in_ready8 !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", in_ready8); end
      bin8 = v; blank8 = b; in_valid8 = 1'b1;
      tick;
      in_valid8 = 1'b0;
      if (k > 0) begin
        checks++;
        if (cyc - prev != 10) begin errors++; $display("FAIL b2b_interval: got %0d expected 10", cyc - prev); end
      end
      prev = cyc;
      n = 0;
      while (!out_valid8 && n < 50) begin tick; n++; end
      checks++;
      if (n != 8) begin errors++; $display("FAIL b2b_latency: got %0d expected 8", n); end
      checks++;
      if (ascii8 !== exp[31:0]) begin
        errors++; $display("FAIL b2b_ascii: got %h expected %h (v=%0d blank=%0d)", ascii8, exp[31:0], v, b);
      end
`ifndef BIN2ASCII_SIGNED_EN
      if (k == 0) begin
        checks++;
        if (ascii8 !== lit) begin errors++; $display("FAIL b2b_200_literal: got %h expected %h", ascii8, lit); end
      end
`endif
    end
    tick;
    out_ready8 = 1'b0;
  endtask

  task automatic test_rst_mid;
    int n, seen;
    n = 0;
    while (!in_ready && n < 100) begin tick; n++; end
    bin_in = 32'd123456789; blank_lz = 1'b0; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (9) tick;
    rst = 1'b1;
    tick;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || ascii_out !== {16{8'h30}}) begin
      errors++; $display("FAIL rst_mid: got valid=%b ready=%b ascii=%h expected 0/0/all 30", out_valid, in_ready, ascii_out);
    end
    rst = 1'b0;
    tick;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b expected 1", in_ready); end
    seen = 0;
    repeat (40) begin
      tick;
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0 || ascii_out !== {16{8'h30}}) begin
      errors++; $display("FAIL rst_mid_discard: got %0d valid cycles ascii=%h expected 0/all 30", seen, ascii_out);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; bin_in = '0; blank_lz = 1'b0; out_ready = 1'b0;
    in_valid8 = 1'b0; bin8 = '0; blank8 = 1'b0; out_ready8 = 1'b0;
    test_reset;
    test_convert;
    test_hold;
    test_back_to_back;
    test_rst_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
